alu_share_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single combinational EX-stage ALU (add/sub/sll/srl/sra on 3-bit control) between the main pipeline EX issue slot (requester 0) and a secondary unit such as an address generator (requester 1). Each cycle it grants at most one valid request and drives that request's operands and control onto the ALU. It captures the ALU result and zero flag into a one-entry output register, then returns the tagged result over a valid/ready response channel.

---
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Purpose:
//   Time-shares one combinational EX-stage ALU between two requesters:
//   requester 0 is the main pipeline EX issue slot, requester 1 is a
//   secondary unit such as an address generator. At most one request is
//   granted per cycle. The granted operands and control go to the ALU, and
//   the ALU result and zero flag are captured into a one-entry output
//   register. That register is drained over a valid/ready response channel
//   and tagged with the owning requester.
//
// Configuration:
//   ALU_ARB_RR_EN  defined   -> round-robin on ties, using a 1-bit pointer
//                               `last` (reset value 1, so req0 wins the first tie)
//                  undefined -> fixed priority, req0 always wins (no pointer)
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational)
//   req{0,1}_a/_b/_ctrl        request operands and ALU operation
//   alu_a, alu_b, alu_ctrl     drive the shared ALU (all zero when idle)
//   alu_out, alu_zero          ALU result and zero flag (combinational)
//   rsp_valid/_ready           response handshake
//   rsp_id, rsp_data, rsp_zero captured owner id, result and zero flag

module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTRLW = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTRLW-1:0] req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTRLW-1:0] req1_ctrl,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTRLW-1:0] alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q;

    logic slot_free;
    logic grant0;
    logic grant1;
    logic grant_any;

    // The output register can accept a new result when it is empty or is
    // being drained in this same cycle. This gives 1 op/cycle back-to-back.
    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign grant_any = grant0 | grant1;

`ifdef ALU_ARB_RR_EN
    // last_q holds the id of the most recent grant. On a tie, the other
    // requester wins.
    logic last_q;

    always_comb begin
        grant0 = slot_free & req0_valid & (~req1_valid | last_q);
        grant1 = slot_free & req1_valid & (~req0_valid | ~last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant_any) begin
            last_q <= grant1;
        end
    end
`else
    // Fixed priority: req1 only gets the ALU when req0 is idle.
    always_comb begin
        grant0 = slot_free & req0_valid;
        grant1 = slot_free & req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux. Idle cycles present add 0+0 so the ALU inputs do not toggle.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // One-entry result register: load on grant, clear valid on a drain with
    // no replacement, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else if (grant_any) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant1;
            rsp_data_q  <= alu_out;
            rsp_zero_q  <= alu_zero;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. It provides its own ALU model,
// runs a directed vector table, hand-written backpressure and reset
// sequences, and a randomized phase checked against a behavioural model.
module tb_alu_share_arbiter;

    localparam int W = 32;
    localparam int C = 3;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [C-1:0] req0_ctrl = '0, req1_ctrl = '0;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [C-1:0] alu_ctrl;
    logic         alu_zero;
    logic         rsp_valid, rsp_id, rsp_zero;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .CTRLW(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero)
    );

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [C-1:0] ctrl);
        case (ctrl)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << b[4:0];
            3'd3:    return a >> b[4:0];
            3'd4:    return W'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // Bench-side ALU
    always_comb begin
        alu_out  = alu_ref(alu_a, alu_b, alu_ctrl);
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [C-1:0] c0, input logic v1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic [C-1:0] c1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        rsp_ready  = rr;
    endtask

    // Entered at posedge+1 with inputs already driven. Checks the
    // combinational grant and mux, then the registered response after the edge.
    task automatic cycle_check(input string tag, input logic er0, input logic er1,
                               input logic ev, input logic eid, input logic [W-1:0] ed,
                               input logic ez);
        logic [W-1:0] ea, eb;
        logic [C-1:0] ec;
        #3;
        ea = er0 ? req0_a : (er1 ? req1_a : '0);
        eb = er0 ? req0_b : (er1 ? req1_b : '0);
        ec = er0 ? req0_ctrl : (er1 ? req1_ctrl : '0);
        check({tag, " req0_ready"}, W'(req0_ready), W'(er0));
        check({tag, " req1_ready"}, W'(req1_ready), W'(er1));
        check({tag, " alu_a"}, alu_a, ea);
        check({tag, " alu_b"}, alu_b, eb);
        check({tag, " alu_ctrl"}, W'(alu_ctrl), W'(ec));
        @(posedge clk);
        #1;
        check({tag, " rsp_valid"}, W'(rsp_valid), W'(ev));
        if (ev) begin
            check({tag, " rsp_id"}, W'(rsp_id), W'(eid));
            check({tag, " rsp_data"}, rsp_data, ed);
            check({tag, " rsp_zero"}, W'(rsp_zero), W'(ez));
        end
    endtask

    typedef struct {
        logic         v0;
        logic [W-1:0] a0, b0;
        logic [C-1:0] c0;
        logic         v1;
        logic [W-1:0] a1, b1;
        logic [C-1:0] c1;
        logic         rr;
        logic         er0, er1, ev, eid;
        logic [W-1:0] ed;
        logic         ez;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic [C-1:0] c0, input logic v1, input logic [W-1:0] a1,
                                input logic [W-1:0] b1, input logic [C-1:0] c1, input logic rr,
                                input logic er0, input logic er1, input logic ev,
                                input logic eid, input logic [W-1:0] ed, input logic ez);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr = rr;
        v.er0 = er0; v.er1 = er1; v.ev = ev; v.eid = eid; v.ed = ed; v.ez = ez;
        return v;
    endfunction

    vec_t vecs[$];

    // Random-phase model state
    logic         m_full, m_id, m_zero, m_last;
    logic [W-1:0] m_data;
    logic         p_v[2];
    logic [W-1:0] p_a[2], p_b[2];
    logic [C-1:0] p_c[2];

    initial begin
        // Tie stimulus first, so the round-robin pointer starts from reset.
        if (RR) begin
            vecs.push_back(mk(1, 7, 7, 0, 1, 9, 9, 1, 1, 1, 0, 1, 0, 14, 0));
            vecs.push_back(mk(1, 7, 7, 0, 1, 9, 9, 1, 1, 0, 1, 1, 1, 0, 1));
            vecs.push_back(mk(1, 7, 7, 0, 1, 9, 9, 1, 1, 1, 0, 1, 0, 14, 0));
            vecs.push_back(mk(1, 7, 7, 0, 1, 9, 9, 1, 1, 0, 1, 1, 1, 0, 1));
        end else begin
            for (int i = 0; i < 4; i++)
                vecs.push_back(mk(1, 7, 7, 0, 1, 9, 9, 1, 1, 1, 0, 1, 0, 14, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // drain to idle
        vecs.push_back(mk(1, 5, 3, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2, 0));  // 5-3
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hffff_fff0, 4, 3, 1, 0, 1, 1, 1,
                          32'h0fff_ffff, 0));                             // srl
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // idle

        // Reset values
        #3;
        check("reset rsp_valid", W'(rsp_valid), 0);
        check("reset rsp_id", W'(rsp_id), 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_zero", W'(rsp_zero), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rr);
            cycle_check($sformatf("vec%0d", i), vecs[i].er0, vecs[i].er1, vecs[i].ev,
                        vecs[i].eid, vecs[i].ed, vecs[i].ez);
        end

        // Backpressure: 1<<4 from req1, then hold with req0 waiting.
        drive(0, 0, 0, 0, 1, 1, 4, 2, 1);
        cycle_check("bp first", 0, 1, 1, 1, 16, 0);
        drive(1, 10, 20, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle_check($sformatf("bp hold%0d", i), 0, 0, 1, 1, 16, 0);
        rsp_ready = 1'b1;
        cycle_check("bp release", 1, 0, 1, 0, 30, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle_check("bp drain", 0, 0, 0, 0, 0, 0);

        // Reset mid-operation with sra 0x80000000 >>> 0 held in the register.
        drive(1, 32'h8000_0000, 0, 4, 0, 0, 0, 0, 0);
        cycle_check("rst load", 1, 0, 1, 0, 32'h8000_0000, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle_check("rst hold", 0, 0, 1, 0, 32'h8000_0000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst rsp_valid", W'(rsp_valid), 0);
        check("rst rsp_id", W'(rsp_id), 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_zero", W'(rsp_zero), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // The pointer is back at its reset value, so req0 wins this tie.
        drive(1, 7, 7, 0, 1, 9, 9, 1, 1);
        cycle_check("post rst tie", 1, 0, 1, 0, 14, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle_check("post rst drain", 0, 0, 0, 0, 0, 0);

        // Randomized phase against the behavioural model.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_full = 0; m_id = 0; m_zero = 0; m_data = '0; m_last = 1;
        for (int r = 0; r < 2; r++) p_v[r] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int g;
            logic free, rr;
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(0, 2) != 0) begin
                    p_v[r] = 1;
                    p_a[r] = $urandom;
                    p_b[r] = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 40)) : $urandom;
                    p_c[r] = C'($urandom_range(0, 4));
                    if ($urandom_range(0, 7) == 0) p_b[r] = p_a[r];
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            drive(p_v[0], p_a[0], p_b[0], p_c[0], p_v[1], p_a[1], p_b[1], p_c[1], rr);
            free = !m_full || rr;
            g = -1;
            if (free) begin
                if (p_v[0] && p_v[1]) g = RR ? (m_last ? 0 : 1) : 0;
                else if (p_v[0]) g = 0;
                else if (p_v[1]) g = 1;
            end
            if (g >= 0) begin
                m_full = 1;
                m_id   = (g == 1);
                m_data = alu_ref(p_a[g], p_b[g], p_c[g]);
                m_zero = (m_data == '0);
                m_last = (g == 1);
            end else if (m_full && rr) begin
                m_full = 0;
            end
            cycle_check($sformatf("rnd%0d", cyc), g == 0, g == 1, m_full, m_id, m_data, m_zero);
            if (g >= 0) p_v[g] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
